// File: rtl/ctrl_decode_pipe.sv
// ctrl_decode_pipe: MIPS main-opcode decoder followed by a STAGES-deep
// control pipeline with hazard stall, stage-0 flush, a safe all-zero
// bundle for illegal opcodes, a sticky error flag and a saturating
// illegal-opcode counter.
module ctrl_decode_pipe #(
    parameter int STAGES = 2,
    parameter bit EXT_EN = 1'b1,
    parameter int CNTW   = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [5:0]      op,
    input  logic            in_valid,
    input  logic            stall,
    input  logic            flush,
    input  logic            err_clr,
    output logic            in_ready,
    output logic            out_valid,
    output logic            regwrite,
    output logic            regdst,
    output logic            alusrc,
    output logic            branch,
    output logic            bne,
    output logic            memwrite,
    output logic            memtoreg,
    output logic            jump,
    output logic            link,
    output logic [2:0]      aluop,
    output logic            out_illegal,
    output logic            err,
    output logic [CNTW-1:0] err_cnt
);

    // Bundle layout: control bits in the upper nine bits, aluop in [2:0].
    localparam int BW         = 12;
    localparam int B_REGWRITE = 11;
    localparam int B_REGDST   = 10;
    localparam int B_ALUSRC   = 9;
    localparam int B_BRANCH   = 8;
    localparam int B_BNE      = 7;
    localparam int B_MEMWRITE = 6;
    localparam int B_MEMTOREG = 5;
    localparam int B_JUMP     = 4;
    localparam int B_LINK     = 3;
    localparam int B_ILLEGAL  = 12;

    // Returns {illegal, bundle}; an illegal opcode yields an all-zero bundle.
    function automatic logic [BW:0] decode_op(input logic [5:0] opcode, input logic ext_en);
        logic [BW:0] d;
        d = '0;
        case (opcode)
            6'b000000: begin // R-type
                d[B_REGWRITE] = 1'b1;
                d[B_REGDST]   = 1'b1;
                d[2:0]        = 3'b010;
            end
            6'b100011: begin // LW
                d[B_REGWRITE] = 1'b1;
                d[B_ALUSRC]   = 1'b1;
                d[B_MEMTOREG] = 1'b1;
                d[2:0]        = 3'b000;
            end
            6'b101011: begin // SW
                d[B_ALUSRC]   = 1'b1;
                d[B_MEMWRITE] = 1'b1;
                d[2:0]        = 3'b000;
            end
            6'b000100: begin // BEQ
                d[B_BRANCH] = 1'b1;
                d[2:0]      = 3'b001;
            end
            6'b000101: begin // BNE
                d[B_BNE] = 1'b1;
                d[2:0]   = 3'b001;
            end
            6'b001000: begin // ADDI
                d[B_REGWRITE] = 1'b1;
                d[B_ALUSRC]   = 1'b1;
                d[2:0]        = 3'b000;
            end
            6'b001010: begin // SLTI
                d[B_REGWRITE] = 1'b1;
                d[B_ALUSRC]   = 1'b1;
                d[2:0]        = 3'b011;
            end
            6'b001101: begin // ORI
                d[B_REGWRITE] = 1'b1;
                d[B_ALUSRC]   = 1'b1;
                d[2:0]        = 3'b100;
            end
            6'b000010: begin // J
                d[B_JUMP] = 1'b1;
            end
            6'b001100: begin // ANDI, only with the extension enabled
                if (ext_en) begin
                    d[B_REGWRITE] = 1'b1;
                    d[B_ALUSRC]   = 1'b1;
                    d[2:0]        = 3'b101;
                end else begin
                    d[B_ILLEGAL] = 1'b1;
                end
            end
            6'b000011: begin // JAL, only with the extension enabled
                if (ext_en) begin
                    d[B_JUMP]     = 1'b1;
                    d[B_LINK]     = 1'b1;
                    d[B_REGWRITE] = 1'b1;
                end else begin
                    d[B_ILLEGAL] = 1'b1;
                end
            end
            default: begin
                d[B_ILLEGAL] = 1'b1;
            end
        endcase
        return d;
    endfunction

    logic [BW:0]                 dec_s;
    logic                        accept_s;
    logic                        ill_accept_s;
    logic [STAGES-1:0]           valid_r;
    logic [STAGES-1:0]           illegal_r;
    logic [STAGES-1:0][BW-1:0]   bundle_r;
    logic                        err_r;
    logic [CNTW-1:0]             err_cnt_r;

    assign dec_s        = decode_op(op, EXT_EN);
    assign accept_s     = in_valid & ~stall & ~flush;
    assign ill_accept_s = accept_s & dec_s[B_ILLEGAL];
    assign in_ready     = ~stall;

    // Control pipeline: flush bubbles stage 0 even under stall, stall freezes all stages.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_r   <= '0;
            illegal_r <= '0;
            bundle_r  <= '0;
        end else begin
            if (flush) begin
                valid_r[0]   <= 1'b0;
                illegal_r[0] <= 1'b0;
                bundle_r[0]  <= '0;
            end else if (!stall) begin
                valid_r[0]   <= in_valid;
                illegal_r[0] <= in_valid & dec_s[B_ILLEGAL];
                bundle_r[0]  <= in_valid ? dec_s[BW-1:0] : {BW{1'b0}};
            end
            if (!stall) begin
                for (int k = 1; k < STAGES; k++) begin
                    valid_r[k]   <= valid_r[k-1];
                    illegal_r[k] <= illegal_r[k-1];
                    bundle_r[k]  <= bundle_r[k-1];
                end
            end
        end
    end

    // Sticky error flag and saturating illegal counter; clear wins over a same-cycle accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_r     <= 1'b0;
            err_cnt_r <= '0;
        end else if (err_clr) begin
            err_r     <= 1'b0;
            err_cnt_r <= '0;
        end else if (ill_accept_s) begin
            err_r <= 1'b1;
            if (!(&err_cnt_r)) begin
                err_cnt_r <= err_cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
            end
        end
    end

    assign out_valid   = valid_r[STAGES-1];
    assign out_illegal = illegal_r[STAGES-1];
    assign regwrite    = bundle_r[STAGES-1][B_REGWRITE];
    assign regdst      = bundle_r[STAGES-1][B_REGDST];
    assign alusrc      = bundle_r[STAGES-1][B_ALUSRC];
    assign branch      = bundle_r[STAGES-1][B_BRANCH];
    assign bne         = bundle_r[STAGES-1][B_BNE];
    assign memwrite    = bundle_r[STAGES-1][B_MEMWRITE];
    assign memtoreg    = bundle_r[STAGES-1][B_MEMTOREG];
    assign jump        = bundle_r[STAGES-1][B_JUMP];
    assign link        = bundle_r[STAGES-1][B_LINK];
    assign aluop       = bundle_r[STAGES-1][2:0];
    assign err         = err_r;
    assign err_cnt     = err_cnt_r;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Bench for ctrl_decode_pipe: two instances share one stimulus stream,
// A with EXT_EN=1/CNTW=8 and B with EXT_EN=0/CNTW=2. Expected bundles are
// queued on accept and popped when an instance shows a new valid output.
module tb_ctrl_decode_pipe;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] op = 6'd0;
    logic       in_valid = 1'b0;
    logic       stall = 1'b0;
    logic       flush = 1'b0;
    logic       err_clr = 1'b0;

    logic       a_rdy, a_ov, a_rw, a_rd, a_as, a_br, a_bne, a_mw, a_mt, a_j, a_l, a_ill, a_err;
    logic [2:0] a_aluop;
    logic [7:0] a_cnt;
    logic       b_rdy, b_ov, b_rw, b_rd, b_as, b_br, b_bne, b_mw, b_mt, b_j, b_l, b_ill, b_err;
    logic [2:0] b_aluop;
    logic [1:0] b_cnt;

    logic [12:0] obs_a, obs_b;
    assign obs_a = {a_ill, a_rw, a_rd, a_as, a_br, a_bne, a_mw, a_mt, a_j, a_l, a_aluop};
    assign obs_b = {b_ill, b_rw, b_rd, b_as, b_br, b_bne, b_mw, b_mt, b_j, b_l, b_aluop};

    int checks = 0;
    int errors = 0;
    logic [12:0] sbq [2][$];
    logic        err_m [2];
    int          cnt_m [2];

    ctrl_decode_pipe #(.STAGES(2), .EXT_EN(1'b1), .CNTW(8)) dut_a (
        .clk(clk), .reset_n(reset_n), .op(op), .in_valid(in_valid), .stall(stall),
        .flush(flush), .err_clr(err_clr), .in_ready(a_rdy), .out_valid(a_ov),
        .regwrite(a_rw), .regdst(a_rd), .alusrc(a_as), .branch(a_br), .bne(a_bne),
        .memwrite(a_mw), .memtoreg(a_mt), .jump(a_j), .link(a_l), .aluop(a_aluop),
        .out_illegal(a_ill), .err(a_err), .err_cnt(a_cnt)
    );

    ctrl_decode_pipe #(.STAGES(2), .EXT_EN(1'b0), .CNTW(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .op(op), .in_valid(in_valid), .stall(stall),
        .flush(flush), .err_clr(err_clr), .in_ready(b_rdy), .out_valid(b_ov),
        .regwrite(b_rw), .regdst(b_rd), .alusrc(b_as), .branch(b_br), .bne(b_bne),
        .memwrite(b_mw), .memtoreg(b_mt), .jump(b_j), .link(b_l), .aluop(b_aluop),
        .out_illegal(b_ill), .err(b_err), .err_cnt(b_cnt)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Expected {illegal, rw, rd, as, br, bne, mw, mt, j, l, aluop} from the decode table.
    function automatic logic [12:0] exp_decode(input logic [5:0] opc, input logic ext);
        case (opc)
            OP_R:    return 13'b0_110000000_010;
            OP_LW:   return 13'b0_101000100_000;
            OP_SW:   return 13'b0_001001000_000;
            OP_BEQ:  return 13'b0_000100000_001;
            OP_BNE:  return 13'b0_000010000_001;
            OP_ADDI: return 13'b0_101000000_000;
            OP_SLTI: return 13'b0_101000000_011;
            OP_ORI:  return 13'b0_101000000_100;
            OP_J:    return 13'b0_000000010_000;
            OP_ANDI: return ext ? 13'b0_101000000_101 : 13'b1_000000000_000;
            OP_JAL:  return ext ? 13'b0_100000011_000 : 13'b1_000000000_000;
            default: return 13'b1_000000000_000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_side(input int s, input string nm, input logic ov, input logic [12:0] obs,
                              input logic [13:0] snap, input logic stl, input int exp_ov,
                              input logic errv, input int cntv);
        logic [12:0] e;
        if (exp_ov >= 0) chk({nm, "_out_valid"}, 32'(ov), 32'(exp_ov));
        if (stl) begin
            chk({nm, "_frozen"}, 32'({ov, obs}), 32'(snap));
        end else if (ov) begin
            chk({nm, "_sb_nonempty"}, 32'(sbq[s].size() != 0), 32'd1);
            if (sbq[s].size() != 0) begin
                e = sbq[s].pop_front();
                chk({nm, "_bundle"}, 32'(obs), 32'(e));
            end
        end else begin
            chk({nm, "_bubble"}, 32'(obs), 32'd0);
        end
        chk({nm, "_err"}, 32'(errv), 32'(err_m[s]));
        chk({nm, "_err_cnt"}, 32'(cntv), 32'(cnt_m[s]));
    endtask

    task automatic cycle(input logic vld, input logic [5:0] opc, input logic stl,
                         input logic fls, input logic clr, input int exp_ov);
        logic [13:0] snap_a, snap_b;
        logic [12:0] ea, eb;
        logic        acc;
        in_valid = vld; op = opc; stall = stl; flush = fls; err_clr = clr;
        #1;
        chk("a_in_ready", 32'(a_rdy), 32'(!stl));
        chk("b_in_ready", 32'(b_rdy), 32'(!stl));
        snap_a = {a_ov, obs_a};
        snap_b = {b_ov, obs_b};
        ea  = exp_decode(opc, 1'b1);
        eb  = exp_decode(opc, 1'b0);
        acc = vld && !stl && !fls;
        if (acc) begin
            sbq[0].push_back(ea);
            sbq[1].push_back(eb);
        end
        if (clr) begin
            err_m[0] = 1'b0; cnt_m[0] = 0;
            err_m[1] = 1'b0; cnt_m[1] = 0;
        end else if (acc) begin
            if (ea[12]) begin err_m[0] = 1'b1; if (cnt_m[0] != 255) cnt_m[0]++; end
            if (eb[12]) begin err_m[1] = 1'b1; if (cnt_m[1] != 3) cnt_m[1]++; end
        end
        @(posedge clk);
        #1;
        check_side(0, "a", a_ov, obs_a, snap_a, stl, exp_ov, a_err, int'(a_cnt));
        check_side(1, "b", b_ov, obs_b, snap_b, stl, exp_ov, b_err, int'(b_cnt));
    endtask

    task automatic check_reset_state(input string nm);
        chk({nm, "_a_ov"},  32'(a_ov),  32'd0);
        chk({nm, "_a_obs"}, 32'(obs_a), 32'd0);
        chk({nm, "_a_err"}, 32'(a_err), 32'd0);
        chk({nm, "_a_cnt"}, 32'(a_cnt), 32'd0);
        chk({nm, "_b_ov"},  32'(b_ov),  32'd0);
        chk({nm, "_b_obs"}, 32'(obs_b), 32'd0);
        chk({nm, "_b_err"}, 32'(b_err), 32'd0);
        chk({nm, "_b_cnt"}, 32'(b_cnt), 32'd0);
    endtask

    task automatic model_reset();
        sbq[0].delete(); sbq[1].delete();
        err_m[0] = 1'b0; err_m[1] = 1'b0;
        cnt_m[0] = 0;    cnt_m[1] = 0;
    endtask

    // Directed stimulus sequence.
    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        reset_n = 1'b1;

        // Back-to-back LW, SW, BEQ: outputs valid on cycles 2, 3, 4.
        cycle(1'b1, OP_LW,  1'b0, 1'b0, 1'b0, 0);
        cycle(1'b1, OP_SW,  1'b0, 1'b0, 1'b0, 1);
        cycle(1'b1, OP_BEQ, 1'b0, 1'b0, 1'b0, 1);
        cycle(1'b0, OP_R,   1'b0, 1'b0, 1'b0, 1);
        cycle(1'b0, OP_R,   1'b0, 1'b0, 1'b0, 0);

        // Full opcode table; B treats ANDI and JAL as illegal.
        cycle(1'b1, OP_R,    1'b0, 1'b0, 1'b0, 0);
        cycle(1'b1, OP_LW,   1'b0, 1'b0, 1'b0, 1);
        cycle(1'b1, OP_SW,   1'b0, 1'b0, 1'b0, 1);
        cycle(1'b1, OP_BEQ,  1'b0, 1'b0, 1'b0, 1);
        cycle(1'b1, OP_BNE,  1'b0, 1'b0, 1'b0, 1);
        cycle(1'b1, OP_ADDI, 1'b0, 1'b0, 1'b0, 1);
        cycle(1'b1, OP_SLTI, 1'b0, 1'b0, 1'b0, 1);
        cycle(1'b1, OP_ORI,  1'b0, 1'b0, 1'b0, 1);
        cycle(1'b1, OP_J,    1'b0, 1'b0, 1'b0, 1);
        cycle(1'b1, OP_ANDI, 1'b0, 1'b0, 1'b0, 1);
        cycle(1'b1, OP_JAL,  1'b0, 1'b0, 1'b0, 1);
        cycle(1'b0, OP_R,    1'b0, 1'b0, 1'b0, 1);
        cycle(1'b0, OP_R,    1'b0, 1'b0, 1'b0, 0);
        chk("b_err_after_sweep", 32'(b_err), 32'd1);
        chk("b_cnt_after_sweep", 32'(b_cnt), 32'd2);

        // Stall for three cycles while ORI sits in stage 0.
        cycle(1'b1, OP_ADDI, 1'b0, 1'b0, 1'b0, 0);
        cycle(1'b1, OP_ORI,  1'b0, 1'b0, 1'b0, 1);
        for (int i = 0; i < 3; i++) cycle(1'b1, OP_SLTI, 1'b1, 1'b0, 1'b0, 1);
        cycle(1'b1, OP_SLTI, 1'b0, 1'b0, 1'b0, 1);
        cycle(1'b0, OP_R,    1'b0, 1'b0, 1'b0, 1);
        cycle(1'b0, OP_R,    1'b0, 1'b0, 1'b0, 0);

        // Flush under stall: R-type is squashed, older LW in stage 1 holds.
        cycle(1'b1, OP_LW,  1'b0, 1'b0, 1'b0, 0);
        cycle(1'b0, OP_R,   1'b0, 1'b0, 1'b0, 1);
        cycle(1'b1, OP_R,   1'b1, 1'b1, 1'b0, 1);
        cycle(1'b0, OP_R,   1'b0, 1'b0, 1'b0, 0);
        cycle(1'b1, OP_ORI, 1'b0, 1'b1, 1'b0, 0);
        cycle(1'b0, OP_R,   1'b0, 1'b0, 1'b0, 0);

        // Bubbles carrying an LW opcode stay all-zero and leave err alone.
        for (int i = 0; i < 3; i++) cycle(1'b0, OP_LW, 1'b0, 1'b0, 1'b0, 0);

        // Counter: clear, five illegal accepts (B saturates at 3), clear with a sixth.
        cycle(1'b0, OP_R, 1'b0, 1'b0, 1'b1, 0);
        for (int i = 0; i < 5; i++) cycle(1'b1, OP_BAD, 1'b0, 1'b0, 1'b0, -1);
        chk("b_cnt_saturated", 32'(b_cnt), 32'd3);
        chk("a_cnt_five", 32'(a_cnt), 32'd5);
        cycle(1'b1, OP_BAD, 1'b0, 1'b0, 1'b1, 1);
        cycle(1'b0, OP_R,   1'b0, 1'b0, 1'b0, 1);
        cycle(1'b0, OP_R,   1'b0, 1'b0, 1'b0, 0);

        // Mid-stream reset discards in-flight work immediately.
        cycle(1'b1, OP_BAD, 1'b0, 1'b0, 1'b0, 0);
        cycle(1'b1, OP_LW,  1'b0, 1'b0, 1'b0, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_state("midreset");
        model_reset();
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        cycle(1'b1, OP_J, 1'b0, 1'b0, 1'b0, 0);
        cycle(1'b0, OP_R, 1'b0, 1'b0, 1'b0, 1);
        cycle(1'b0, OP_R, 1'b0, 1'b0, 1'b0, 0);

        chk("a_sb_drained", 32'(sbq[0].size()), 32'd0);
        chk("b_sb_drained", 32'(sbq[1].size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_decode_pipe.md
# ctrl_decode_pipe

Parametrised successor to the single-cycle MIPS main decoder. It decodes the 6-bit opcode in ID and carries the resulting control bundle through STAGES registered pipeline stages (ID/EX, EX/MEM, …), with hazard stall and flush. Illegal opcodes are decoded to a safe all-zero bundle rather than X. A sticky error flag and a saturating illegal-opcode counter make them observable. It sits between instruction fetch/ID and the datapath control inputs of the pipelined core.

## Interface
Parameters:
- STAGES, 2, number of registered stages between `op` and the outputs (1..4).
- EXT_EN, 1, 1 = ANDI and JAL decoded; 0 = both treated as illegal.
- CNTW, 8, width of the illegal-opcode counter.

Ports:
- clk  in  1  clock, all flops on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- op  in  6  opcode of the instruction in ID.
- in_valid  in  1  `op` holds a real instruction this cycle.
- stall  in  1  hazard stall: freeze every stage.
- flush  in  1  squash the instruction entering stage 0 (branch/jump taken).
- err_clr  in  1  synchronous clear of `err` and `err_cnt`.
- in_ready  out  1  combinational, equals !stall.
- out_valid  out  1  last stage holds a valid instruction.
- regwrite, regdst, alusrc, branch, bne, memwrite, memtoreg, jump, link  out  1 each  control bits at the last stage.
- aluop  out  3  ALU operation at the last stage.
- out_illegal  out  1  last-stage instruction had an illegal opcode.
- err  out  1  sticky: any illegal opcode accepted since reset or clear.
- err_cnt  out  CNTW  count of accepted illegal opcodes, saturating.

## Operation
- aluop encoding: 000 add, 001 sub, 010 R-type (use funct), 011 slt, 100 or, 101 and.
- Decode table; fields not listed are 0:
  - R 000000: regwrite, regdst, aluop=010.
  - LW 100011: regwrite, alusrc, memtoreg, aluop=000.
  - SW 101011: alusrc, memwrite, aluop=000.
  - BEQ 000100: branch, aluop=001.
  - BNE 000101: bne, aluop=001.
  - ADDI 001000: regwrite, alusrc, aluop=000.
  - SLTI 001010: regwrite, alusrc, aluop=011.
  - ORI 001101: regwrite, alusrc, aluop=100.
  - J 000010: jump.
  - ANDI 001100 (EXT_EN only): regwrite, alusrc, aluop=101.
  - JAL 000011 (EXT_EN only): jump, link, regwrite.
  - Any other opcode: all-zero bundle, illegal=1.
- Each stage holds {valid, illegal, 12-bit bundle}.
- An invalid stage always carries an all-zero bundle (bubble).
- Outputs are driven directly from the last stage's flops, with no output logic.
- Stage 0 update, in priority order:
  - flush: load a bubble (valid=0, illegal=0), even if stall is high.
  - else stall: hold.
  - else: load {in_valid, decode(op)}, with bundle and illegal forced to 0 when in_valid=0.
- Stage k>0 update: if stall, hold; else copy stage k-1.
- flush affects stage 0 only.
- Accepting an instruction means in_valid & !stall & !flush.
- Illegal accept:
  - err is set.
  - err_cnt increments, saturating at 2^CNTW-1.
- err_clr clears err and err_cnt to 0 in that cycle. It takes priority over a simultaneous illegal accept, which is not counted.

## Timing
- Reset (reset_n low, asynchronous) sets every output and internal flop to 0:
  - out_valid=0, all control bits 0, aluop=000.
  - out_illegal=0, err=0, err_cnt=0.
- Release of reset_n is synchronised externally. The first decode occurs on the first rising edge with reset_n high.
- Reset mid-stream discards all in-flight instructions immediately.
- Latency: an instruction accepted at edge N appears on the outputs after edge N+STAGES-1, i.e. STAGES cycles after `op` is presented, with no stalls.
- Each stalled cycle adds exactly one cycle of latency to every in-flight instruction. No instruction is duplicated or dropped by a stall.
- in_ready is combinational from stall, with no flop.
- Throughput is one instruction per cycle when stall=0.

## Test plan
- Reset: drive reset_n low mid-stream with STAGES=2 -> all outputs 0 within the same cycle, err_cnt=0. After release, LW then SW then BEQ back-to-back -> out_valid on cycles 2,3,4 with (regwrite,alusrc,memtoreg,aluop)=(1,1,1,000), then memwrite=1/alusrc=1, then branch=1/aluop=001.
- Full table sweep: each of the 11 opcodes with EXT_EN=1 -> bundle exactly as listed. Rerun with EXT_EN=0 -> 001100 and 000011 give all-zero bundle, out_illegal=1, err=1, err_cnt=2.
- Stall: ADDI, ORI, SLTI, with stall high for 3 cycles while ORI is in stage 0 -> outputs frozen for 3 cycles. Order ADDI(000), ORI(100), SLTI(011) is preserved, each appearing exactly once.
- Flush: flush with in_valid=1, op=R-type, stall=1 -> that instruction never reaches the outputs and a bubble (out_valid=0, all zeros) appears. The older instruction in stage 1 holds while stall=1.
- Counter: CNTW=2, 5 illegal opcodes (e.g. 111111) -> err_cnt saturates at 3. err_clr together with a 6th illegal accept -> err=0, err_cnt=0.
- Bubbles: in_valid=0 with op=100011 -> out_valid=0 and every control bit 0; err is unchanged.
